// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multicycle CPU sequencer.
// Contents: state_t state encoding, STATE_W, stage-enable bit indices.
package cpu_seq_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned NUM_STAGES = 5;

  // Encoded sequencer state; 6 and 7 are illegal and recover to FETCH.
  typedef enum logic [STATE_W-1:0] {
    FETCH         = 3'd0,
    DECODE        = 3'd1,
    EXECUTE       = 3'd2,
    MEMORY_ACCESS = 3'd3,
    WRITE_BACK    = 3'd4,
    HALTED        = 3'd5
  } state_t;

  // Bit positions inside the one-hot stage-enable vector.
  localparam int unsigned EN_FETCH  = 0;
  localparam int unsigned EN_DECODE = 1;
  localparam int unsigned EN_EXEC   = 2;
  localparam int unsigned EN_MEM    = 3;
  localparam int unsigned EN_WB     = 4;

endpackage

// File: rtl/cpu_seq_if.sv
// Control/status bundle between decode logic and the sequencer.
// master: drives stall, mem_waitrequest, skip_mem, skip_wb, halt_req;
//         observes state, stage enables, instr_done, active, timeout_err, counters.
// slave:  the sequencer side (directions reversed).
interface cpu_seq_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_seq_pkg::*;

  logic             stall;
  logic             mem_waitrequest;
  logic             skip_mem;
  logic             skip_wb;
  logic             halt_req;
  state_t           state;
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             mem_en;
  logic             wb_en;
  logic             instr_done;
  logic             active;
  logic             timeout_err;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output stall, mem_waitrequest, skip_mem, skip_wb, halt_req,
    input  state, fetch_en, decode_en, exec_en, mem_en, wb_en,
    input  instr_done, active, timeout_err, cycle_count, instr_count
  );

  modport slave (
    input  stall, mem_waitrequest, skip_mem, skip_wb, halt_req,
    output state, fetch_en, decode_en, exec_en, mem_en, wb_en,
    output instr_done, active, timeout_err, cycle_count, instr_count
  );

endinterface

// File: rtl/cpu_sequencer_sat_counter.sv
// Saturating up-counter: clr has priority, inc holds at all-ones.
// Ports: clk, clr (synchronous clear), inc, count[W-1:0].
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle MIPS control sequencer with wait-request handshake, stage
// skipping, halt state, optional wait timeout and saturating perf counters.
// Ports: clk, reset (sync, active-high), bus (cpu_seq_if.slave):
//   in  stall, mem_waitrequest, skip_mem, skip_wb, halt_req
//   out state, fetch/decode/exec/mem/wb_en, instr_done, active,
//       timeout_err, cycle_count, instr_count
// Macro CPU_SEQ_PERF_EN: when defined, cycle_count/instr_count are real
// counters; otherwise both are tied to zero.
module cpu_sequencer #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 0,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic     clk,
  input  logic     reset,
  cpu_seq_if.slave bus
);
  import cpu_seq_pkg::*;

  state_t                state_q, state_d;
  logic                  instr_done_q, instr_done_d;
  logic                  timeout_q;
  logic                  complete_c, timeout_c;
  logic                  in_wait_state_c, active_c;
  logic                  wait_inc_c, wait_clr_c;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [NUM_STAGES-1:0] stage_en_c;

  assign in_wait_state_c = (state_q == FETCH) || (state_q == MEMORY_ACCESS);
  assign active_c        = (state_q != HALTED);

  // State, completion pulse and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      instr_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
      timeout_q    <= timeout_q | timeout_c;
    end
  end

  // Next state: HALTED absorbs, stall freezes, wait-request holds or times out.
  always_comb begin
    state_d    = state_q;
    complete_c = 1'b0;
    timeout_c  = 1'b0;
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (!bus.stall) begin
      if (in_wait_state_c && bus.mem_waitrequest) begin
        if ((MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
          state_d   = HALTED;
          timeout_c = 1'b1;
        end
      end else begin
        case (state_q)
          FETCH:   state_d = DECODE;
          DECODE:  state_d = EXECUTE;
          EXECUTE: begin
            if (bus.halt_req) begin
              state_d = HALTED;
            end else if (!bus.skip_mem) begin
              state_d = MEMORY_ACCESS;
            end else if (!bus.skip_wb) begin
              state_d = WRITE_BACK;
            end else begin
              state_d    = FETCH;
              complete_c = 1'b1;
            end
          end
          MEMORY_ACCESS: begin
            if (bus.skip_wb) begin
              state_d    = FETCH;
              complete_c = 1'b1;
            end else begin
              state_d = WRITE_BACK;
            end
          end
          WRITE_BACK: begin
            state_d    = FETCH;
            complete_c = 1'b1;
          end
          default: state_d = FETCH;
        endcase
      end
    end
    instr_done_d = bus.stall ? instr_done_q : complete_c;
  end

  // Wait counter counts unstalled wait-request cycles and clears on any state change.
  assign wait_inc_c = !bus.stall && bus.mem_waitrequest && in_wait_state_c;
  assign wait_clr_c = reset || (state_d != state_q);

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .clr   (wait_clr_c),
    .inc   (wait_inc_c),
    .count (wait_cnt)
  );

  // One-hot stage enables; all low in HALTED.
  always_comb begin
    stage_en_c = '0;
    case (state_q)
      FETCH:         stage_en_c[EN_FETCH]  = 1'b1;
      DECODE:        stage_en_c[EN_DECODE] = 1'b1;
      EXECUTE:       stage_en_c[EN_EXEC]   = 1'b1;
      MEMORY_ACCESS: stage_en_c[EN_MEM]    = 1'b1;
      WRITE_BACK:    stage_en_c[EN_WB]     = 1'b1;
      default:       stage_en_c = '0;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.fetch_en    = stage_en_c[EN_FETCH];
  assign bus.decode_en   = stage_en_c[EN_DECODE];
  assign bus.exec_en     = stage_en_c[EN_EXEC];
  assign bus.mem_en      = stage_en_c[EN_MEM];
  assign bus.wb_en       = stage_en_c[EN_WB];
  assign bus.instr_done  = instr_done_q;
  assign bus.active      = active_c;
  assign bus.timeout_err = timeout_q;

`ifdef CPU_SEQ_PERF_EN
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (active_c),
    .count (bus.cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (complete_c),
    .count (bus.instr_count)
  );
`else
  assign bus.cycle_count = CNT_W'(0);
  assign bus.instr_count = CNT_W'(0);
`endif

endmodule
